// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N               = 16;
    localparam int unsigned SEL_W           = 4;
    localparam int unsigned QUANTUM_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StHandoff = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick_16.sv
// Combinational round-robin pick: first asserted request searching upward from pointer+1,
// wrapping 15 -> 0, so the pointer position itself is considered last.
module rr_pick_16
    import mux_arb_pkg::*;
(
    input  logic [N-1:0]     request_i,
    input  logic [SEL_W-1:0] pointer_i,
    output logic             found_o,
    output logic [SEL_W-1:0] index_o,
    output logic [N-1:0]     onehot_o
);

    logic             found;
    logic [SEL_W-1:0] index;
    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = pointer_i + SEL_W'(k);
            if (!found && request_i[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

    assign found_o  = found;
    assign index_o  = index;
    assign onehot_o = found ? (N'(1) << index) : '0;

endmodule

// File: rtl/mux_rr_arbiter_16.sv
// Round-robin arbiter sharing one 16:1 mux; all outputs registered.
// Optional hold-time limit enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter_16
  import mux_arb_pkg::*;
#(
  parameter int unsigned QUANTUM = QUANTUM_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     request_lines,
  output logic [N-1:0]     grant_lines,
  output logic [SEL_W-1:0] select_lines,
  output logic             grant_valid
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             hold_expired;

  logic             pick_found;
  logic [SEL_W-1:0] pick_index;
  logic [N-1:0]     pick_onehot;

  rr_pick_16 u_pick (
    .request_i (request_lines),
    .pointer_i (ptr_q),
    .found_o   (pick_found),
    .index_o   (pick_index),
    .onehot_o  (pick_onehot)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] QuantumLast = 8'(QUANTUM - 1);

  logic [7:0] cnt_q, cnt_d;

  // Only yield the mux when someone else is actually waiting for it.
  assign hold_expired = (cnt_q == QuantumLast) && (|(request_lines & ~grant_q));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle, StHandoff: begin
        if (pick_found) begin
          state_d = StGrant;
          grant_d = pick_onehot;
          sel_d   = pick_index;
          ptr_d   = pick_index;
          valid_d = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = StIdle;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      StGrant: begin
        if (!request_lines[sel_q] || hold_expired) begin
          state_d = StHandoff;
          grant_d = '0;
          valid_d = 1'b0;
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d = (cnt_q == QuantumLast) ? cnt_q : cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= SEL_W'(N - 1);
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_lines  = grant_q;
  assign select_lines = sel_q;
  assign grant_valid  = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter_16.sv
// Directed bench for mux_rr_arbiter_16; expectations follow MUX_ARB_TIMEOUT_EN if defined.
module tb_mux_rr_arbiter_16;

  logic        clk;
  logic        reset;
  logic [15:0] request_lines;
  logic [15:0] grant_lines;
  logic [3:0]  select_lines;
  logic        grant_valid;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter_16 #(
    .QUANTUM (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .request_lines (request_lines),
    .grant_lines   (grant_lines),
    .select_lines  (select_lines),
    .grant_valid   (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] g, input logic [3:0] s,
                           input logic v);
    check({tag, ".grant"}, grant_lines, g);
    check({tag, ".select"}, {12'd0, select_lines}, {12'd0, s});
    check({tag, ".valid"}, {15'd0, grant_valid}, {15'd0, v});
  endtask

  initial begin
    logic [15:0] exp_g;
    logic [3:0]  exp_s;
    logic        exp_v;

    reset         = 1'b1;
    request_lines = 16'hFFFF;
    tick();
    tick();
    check_out("reset", 16'h0000, 4'd0, 1'b0);

    // Single request and handoff back to idle.
    reset         = 1'b0;
    request_lines = 16'h0020;
    tick();
    check_out("single_grant", 16'h0020, 4'd5, 1'b1);
    request_lines = 16'h0000;
    tick();
    check_out("single_handoff", 16'h0000, 4'd5, 1'b0);
    tick();
    check_out("single_idle", 16'h0000, 4'd5, 1'b0);

    // Rotation from reset pointer: 0, 15, 0 with dead cycles between.
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    request_lines = 16'h8001;
    tick();
    check_out("rot_g0", 16'h0001, 4'd0, 1'b1);
    request_lines = 16'h8000;
    tick();
    check_out("rot_h0", 16'h0000, 4'd0, 1'b0);
    request_lines = 16'h8001;
    tick();
    check_out("rot_g15", 16'h8000, 4'd15, 1'b1);
    request_lines = 16'h0001;
    tick();
    check_out("rot_h15", 16'h0000, 4'd15, 1'b0);
    request_lines = 16'h8001;
    tick();
    check_out("rot_g0b", 16'h0001, 4'd0, 1'b1);

    // Wrap: pointer 14, requests 0 and 1 -> 0 wins.
    request_lines = 16'h0000;
    tick();
    tick();
    request_lines = 16'h4000;
    tick();
    check_out("wrap_g14", 16'h4000, 4'd14, 1'b1);
    request_lines = 16'h0003;
    tick();
    check_out("wrap_h", 16'h0000, 4'd14, 1'b0);
    tick();
    check_out("wrap_g0", 16'h0001, 4'd0, 1'b1);

    // Sole requester re-granted through handoff.
    request_lines = 16'h0000;
    tick();
    request_lines = 16'h0001;
    tick();
    check_out("regrant", 16'h0001, 4'd0, 1'b1);

    // Held 0x0003 from reset: timeout rotates, otherwise port 0 keeps the mux.
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    request_lines = 16'h0003;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef MUX_ARB_TIMEOUT_EN
      exp_v = (k % 5) != 4;
      exp_s = 4'((k / 5) % 2);
      if ((k % 5) == 4) exp_s = 4'(((k / 5) % 2));
      exp_g = exp_v ? (16'h0001 << exp_s) : 16'h0000;
`else
      exp_v = 1'b1;
      exp_s = 4'd0;
      exp_g = 16'h0001;
`endif
      check_out($sformatf("hold_k%0d", k), exp_g, exp_s, exp_v);
    end

    // Async reset between edges while granted.
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 16'h0000, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    request_lines = 16'h8001;
    tick();
    check_out("post_reset_g0", 16'h0001, 4'd0, 1'b1);
    request_lines = 16'h8000;
    tick();
    tick();
    check_out("post_reset_g15", 16'h8000, 4'd15, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
